bin2bcd_seq: RTL and testbench
==============================

// Module: bin2bcd_seq
// PURPOSE
// - Sequential (iterative double-dabble) binary-to-BCD converter between the 0..999 event counter and the
//   per-digit 7-segment decoders; replaces the combinational unrolled loop with a start/done handshake.
// - Converts one BIN_W-bit value per request, one shift step per clock; result held stable for the decoders.
// PARAMETERS
// - BIN_W   10  width of binary input
// - DIGITS  3   number of BCD output digits (4 bits each, digit 0 = ones in bcd_out[3:0])
// PORTS
// - clk       in   1           system clock (CLOCK_50 at top level)
// - resetn    in   1           synchronous, active-low reset
// - start     in   1           request; sampled on rising clk when state is IDLE or DONE
// - bin_in    in   BIN_W       binary value; sampled only on an accepted start
// - busy      out  1           high while a conversion is in progress (SHIFT state)
// - done      out  1           one-cycle pulse; bcd_out/overflow valid and updated in this cycle
// - bcd_out   out  4*DIGITS    last converted result; hundreds in [11:8] for defaults
// - overflow  out  1           last converted input exceeded 10**DIGITS-1
// BEHAVIOUR
// - One clock; reset is synchronous and active-low (resetn, sampled on rising clk).
// - Reset values: state=IDLE, busy=0, done=0, bcd_out=0, overflow=0, shift register=0.
// - FSM IDLE -> SHIFT on start; SHIFT -> DONE after BIN_W steps; DONE -> SHIFT if start else IDLE.
// - Accept: at edge k with start=1 in IDLE/DONE: shreg <= {4*DIGITS'b0, bin_in}, step count <= 0,
//   ovf_latched <= (bin_in > 10**DIGITS-1); busy=1 from cycle k+1.
// - SHIFT step (one per cycle): every BCD digit field >=5 gets +3 (4-bit, no carry out), then whole
//   register (4*DIGITS+BIN_W bits) shifts left 1; after BIN_W steps digits hold the result.
// - Latency: start accepted at edge k -> done=1 and bcd_out updated during cycle k+BIN_W+1 (11 for default).
// - done high exactly one cycle; busy=0 in the DONE cycle; busy and done never both 1.
// - Overflow: if ovf_latched, bcd_out <= all digits 4'h9 (saturate) and overflow <= 1; else overflow <= 0.
// - start while busy (SHIFT) is ignored, not queued; bin_in changes during SHIFT have no effect.
// - start in DONE cycle is accepted (back-to-back: one conversion per BIN_W+1 cycles).
// - bcd_out/overflow change only in the DONE cycle or on reset; otherwise held.
// - resetn=0 mid-conversion aborts: outputs return to reset values next edge, no done pulse issued.
// - BIN_W=0 or DIGITS=0 illegal; elaboration-time check.
// STRUCTURE
// - Shared package bcd_pkg: state enum {IDLE, SHIFT, DONE}, BCD_DIGIT_W=4, constant function pow10(n),
//   localparam for the 7-seg digit encoding used by the downstream decoders.
// - Sub-module bcd_add3: combinational 4-bit digit corrector (in>=5 ? in+3 : in), instantiated DIGITS times.
// - Step counter width $clog2(BIN_W+1); no other sub-blocks.
// TESTING
// - Reset, then start with bin_in=0 -> done at cycle 11, bcd_out=12'h000, overflow=0.
// - bin_in=507 -> bcd_out=12'h507 at cycle 11; bin_in=999 -> 12'h999, overflow=0.
// - bin_in=1023 -> bcd_out=12'h999, overflow=1; following bin_in=42 -> 12'h042, overflow=0.
// - start pulsed at cycles 3 and 7 of a conversion of 123 with bin_in=456 -> ignored, result 12'h123, single done.
// - Back-to-back: start held high with 1,2,3 presented at accept edges -> done every 11 cycles, 001/002/003.
// - resetn=0 at step 5 of 888 -> no done, bcd_out=0, busy=0; next start 888 -> 12'h888.
// - Exhaustive sweep 0..1023 against a reference model: bcd_out, overflow, latency checked each value.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared definitions for the binary-to-BCD path feeding the 7-segment decoders.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int BCD_DIGIT_W = 4;

  // Active-high segment patterns {g,f,e,d,c,b,a} for digits 9 down to 0;
  // digit d occupies SEG7_TABLE[7*d +: 7].
  localparam logic [69:0] SEG7_TABLE = {
    7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D,
    7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  // 10**n, used to derive the largest representable value for a digit count.
  function automatic longint unsigned pow10(input int n);
    longint unsigned r;
    r = 64'd1;
    for (int i = 0; i < n; i++) begin
      r = r * 64'd10;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit corrector: a digit of 5 or more gets +3 so the
// following left shift carries correctly into the next decade.
module bcd_add3
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] d_in,
  output logic [BCD_DIGIT_W-1:0] d_out
);

  // Correct the digit before the shift; 4-bit result, no carry out.
  always_comb begin
    d_out = d_in;
    if (d_in >= 4'd5) begin
      d_out = d_in + 4'd3;
    end
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// Iterative binary-to-BCD converter with a start/done handshake.
// One shift step per clock; the result register is held between conversions.
//
//   state | meaning
//   IDLE  | waiting for start, result held
//   SHIFT | conversion running, one double-dabble step per clock
//   DONE  | one-cycle result-valid pulse; a new start is accepted here
module bin2bcd_seq
  import bcd_pkg::*;
#(
  parameter int BIN_W  = 10,
  parameter int DIGITS = 3
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          start,
  input  logic [BIN_W-1:0]              bin_in,
  output logic                          busy,
  output logic                          done,
  output logic [BCD_DIGIT_W*DIGITS-1:0] bcd_out,
  output logic                          overflow
);

  localparam int BCD_W = BCD_DIGIT_W * DIGITS;
  localparam int SR_W  = BCD_W + BIN_W;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam longint unsigned MAX_VAL = pow10(DIGITS) - 64'd1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(BIN_W - 1);

  if (BIN_W < 1 || DIGITS < 1) begin : g_param_check
    $error("bin2bcd_seq: BIN_W and DIGITS must both be at least 1");
  end

  state_t            state_q;
  state_t            state_d;
  logic [SR_W-1:0]   shreg_q;
  logic [CNT_W-1:0]  step_q;
  logic              ovf_lat_q;
  logic [BCD_W-1:0]  bcd_q;
  logic              ovf_q;

  logic [BCD_W-1:0]  digits_fix;
  logic [SR_W-1:0]   corrected;
  logic [SR_W-1:0]   shreg_step;
  logic              accept;
  logic              last_step;

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    bcd_add3 u_add3 (
      .d_in  (shreg_q[BIN_W + BCD_DIGIT_W*i +: BCD_DIGIT_W]),
      .d_out (digits_fix[BCD_DIGIT_W*i +: BCD_DIGIT_W])
    );
  end

  // One double-dabble step: correct every digit, then shift the whole register.
  always_comb begin
    corrected  = {digits_fix, shreg_q[BIN_W-1:0]};
    shreg_step = corrected << 1;
    accept     = start && (state_q == IDLE || state_q == DONE);
    last_step  = (state_q == SHIFT) && (step_q == LAST_STEP);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        busy = 1'b1;
        if (step_q == LAST_STEP) begin
          state_d = DONE;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = start ? SHIFT : IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Shift register, step counter and result registers.
  // The result is written on the last step edge so it is already valid
  // during the DONE cycle.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      shreg_q   <= '0;
      step_q    <= '0;
      ovf_lat_q <= 1'b0;
      bcd_q     <= '0;
      ovf_q     <= 1'b0;
    end else if (accept) begin
      shreg_q   <= {{BCD_W{1'b0}}, bin_in};
      step_q    <= '0;
      ovf_lat_q <= (64'(bin_in) > MAX_VAL);
    end else if (state_q == SHIFT) begin
      shreg_q <= shreg_step;
      step_q  <= step_q + CNT_W'(1);
      if (last_step) begin
        bcd_q <= ovf_lat_q ? {DIGITS{4'h9}} : shreg_step[SR_W-1 -: BCD_W];
        ovf_q <= ovf_lat_q;
      end
    end
  end

  assign bcd_out  = bcd_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: directed cases, start-while-busy,
// back-to-back requests, reset abort, and a full sweep plus random values.
module tb_bin2bcd_seq;

  localparam int BIN_W  = 10;
  localparam int DIGITS = 3;
  localparam int LAT    = BIN_W + 1;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic [9:0]  bin_in = '0;
  logic        busy;
  logic        done;
  logic [11:0] bcd_out;
  logic        overflow;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  bin2bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .start    (start),
    .bin_in   (bin_in),
    .busy     (busy),
    .done     (done),
    .bcd_out  (bcd_out),
    .overflow (overflow)
  );

  // Reference: decimal digits by plain arithmetic, saturated above 999.
  function automatic logic [11:0] ref_bcd(input int v);
    if (v > 999) return 12'h999;
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [31:0] ref_ovf(input int v);
    return (v > 999) ? 32'd1 : 32'd0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One conversion; optionally pulses start (with bin_in=456) at cycles 3 and 7.
  task automatic conv(input int val, input bit poke, input int gap, input string tag);
    logic [11:0] prev;
    int lat;
    bit busy_ok;
    bit hold_ok;
    bit extra_done;
    @(negedge clk);
    prev   = bcd_out;
    start  = 1'b1;
    bin_in = val[9:0];
    @(negedge clk);
    start  = 1'b0;
    lat = 0; busy_ok = 1'b1; hold_ok = 1'b1; extra_done = 1'b0;
    for (int n = 1; n <= 30; n++) begin
      if (n > 1) @(negedge clk);
      if (done) begin
        lat = n;
        break;
      end
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (bcd_out !== prev) hold_ok = 1'b0;
      start  = poke && (n == 3 || n == 7);
      bin_in = start ? 10'd456 : 10'($urandom);
    end
    start = 1'b0;
    check($sformatf("%s(%0d) latency", tag, val), lat, LAT);
    check($sformatf("%s(%0d) bcd", tag, val), {20'd0, bcd_out}, {20'd0, ref_bcd(val)});
    check($sformatf("%s(%0d) ovf", tag, val), {31'd0, overflow}, ref_ovf(val));
    check($sformatf("%s(%0d) busy in done", tag, val), {31'd0, busy}, 32'd0);
    check($sformatf("%s(%0d) busy during shift", tag, val), {31'd0, busy_ok}, 32'd1);
    check($sformatf("%s(%0d) result held", tag, val), {31'd0, hold_ok}, 32'd1);
    @(negedge clk);
    if (done) extra_done = 1'b1;
    repeat (gap) begin
      @(negedge clk);
      if (done) extra_done = 1'b1;
    end
    check($sformatf("%s(%0d) single done", tag, val), {31'd0, extra_done}, 32'd0);
  endtask

  initial begin
    int lat;
    bit seen;

    resetn = 1'b0;
    repeat (3) @(negedge clk);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);
    check("reset bcd", {20'd0, bcd_out}, 32'd0);
    check("reset ovf", {31'd0, overflow}, 32'd0);
    resetn = 1'b1;

    conv(0,    1'b0, 2, "dir");
    conv(507,  1'b0, 1, "dir");
    conv(999,  1'b0, 0, "dir");
    conv(1023, 1'b0, 3, "dir");
    conv(42,   1'b0, 1, "dir");
    conv(123,  1'b1, 5, "ignore");

    // Back-to-back: start held high, new value presented before each accept.
    @(negedge clk);
    start  = 1'b1;
    bin_in = 10'd1;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      bin_in = 10'(j + 2);
      lat = 0;
      for (int n = 1; n <= 30; n++) begin
        if (n > 1) @(negedge clk);
        if (done) begin
          lat = n;
          break;
        end
      end
      if (j == 2) start = 1'b0;
      check($sformatf("b2b%0d latency", j), lat, LAT);
      check($sformatf("b2b%0d bcd", j), {20'd0, bcd_out}, {20'd0, ref_bcd(j + 1)});
    end
    @(negedge clk);
    check("b2b stop done", {31'd0, done}, 32'd0);
    check("b2b stop busy", {31'd0, busy}, 32'd0);

    // Reset in the middle of a conversion of 888.
    @(negedge clk);
    start  = 1'b1;
    bin_in = 10'd888;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    check("abort busy", {31'd0, busy}, 32'd0);
    check("abort done", {31'd0, done}, 32'd0);
    check("abort bcd", {20'd0, bcd_out}, 32'd0);
    check("abort ovf", {31'd0, overflow}, 32'd0);
    resetn = 1'b1;
    seen = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check("abort no done", {31'd0, seen}, 32'd0);
    conv(888, 1'b0, 1, "after_abort");

    for (int v = 0; v < 1024; v++) begin
      conv(v, 1'b0, int'($urandom_range(0, 2)), "sweep");
    end
    for (int r = 0; r < 100; r++) begin
      conv(int'($urandom_range(0, 1023)), 1'b0, int'($urandom_range(0, 3)), "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
